// File: rtl/enemy_pkg.sv
// Shared types and default constants for the enemy pump/inflate logic.
package enemy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED  = 2'd1,
        POPPING = 2'd2
    } inflate_state_t;

    localparam int LEVEL_W            = 3;
    localparam int DEF_POP_LEVEL      = 4;
    localparam int DEF_DEFLATE_FRAMES = 30;
    localparam int DEF_POP_FRAMES     = 20;

endpackage

// File: rtl/enemy_deflate_timer.sv
// Per-enemy inflation level register with its idle deflate frame counter.
module enemy_deflate_timer
    import enemy_pkg::*;
#(
    parameter int POP_LEVEL      = DEF_POP_LEVEL,
    parameter int DEFLATE_FRAMES = DEF_DEFLATE_FRAMES
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Frame_tick,
    input  logic               inc,
    input  logic               hold,
    input  logic               clr,
    output logic [LEVEL_W-1:0] level
);

    localparam int CNT_W = $clog2(DEFLATE_FRAMES + 1);

    logic [LEVEL_W-1:0] level_q;
    logic [CNT_W-1:0]   cnt_q;

    // Pop clear beats a pump, a pump beats deflation, and a held or empty enemy keeps its counter at zero.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            level_q <= '0;
            cnt_q   <= '0;
        end else if (clr) begin
            level_q <= '0;
            cnt_q   <= '0;
        end else if (inc) begin
            if (level_q != LEVEL_W'(POP_LEVEL)) begin
                level_q <= level_q + LEVEL_W'(1);
            end
            cnt_q <= '0;
        end else if (hold || (level_q == '0)) begin
            cnt_q <= '0;
        end else if (Frame_tick) begin
            if (cnt_q == CNT_W'(DEFLATE_FRAMES - 1)) begin
                level_q <= level_q - LEVEL_W'(1);
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/enemy_inflate_ctrl.sv
// Harpoon target arbiter, pump/pop FSM and pop animation timer across all enemies.
module enemy_inflate_ctrl
    import enemy_pkg::*;
#(
    parameter int NUM_ENEMIES    = 4,
    parameter int POP_LEVEL      = DEF_POP_LEVEL,
    parameter int DEFLATE_FRAMES = DEF_DEFLATE_FRAMES,
    parameter int POP_FRAMES     = DEF_POP_FRAMES
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           Frame_tick,
    input  logic                           Harpoon_active,
    input  logic [NUM_ENEMIES-1:0]         Harpoon_hit,
    input  logic                           Pump_press,
    output logic                           Target_valid,
    output logic [$clog2(NUM_ENEMIES)-1:0] Target_id,
    output logic [3*NUM_ENEMIES-1:0]       Inflate_level,
    output logic [NUM_ENEMIES-1:0]         Enemy_frozen,
    output logic [NUM_ENEMIES-1:0]         Pop_anim,
    output logic [NUM_ENEMIES-1:0]         Enemy_popped,
    output logic                           Score_pulse
);

    localparam int ID_W      = $clog2(NUM_ENEMIES);
    localparam int POP_CNT_W = $clog2(POP_FRAMES + 1);

    inflate_state_t         state_q;
    logic [ID_W-1:0]        target_q;
    logic [ID_W-1:0]        lock_idx;
    logic                   target_valid_q;
    logic [NUM_ENEMIES-1:0] pop_anim_q;
    logic [NUM_ENEMIES-1:0] popped_q;
    logic                   score_q;
    logic [POP_CNT_W-1:0]   pop_cnt_q;
    logic [NUM_ENEMIES-1:0] inc;
    logic [NUM_ENEMIES-1:0] hold;
    logic [NUM_ENEMIES-1:0] clr;
    logic [LEVEL_W-1:0]     level [NUM_ENEMIES];
    logic [LEVEL_W-1:0]     target_level;
    logic                   lock_now;
    logic                   pump_now;
    logic                   pop_done;

    // Priority encoder: the lowest-index overlapping enemy wins the lock.
    always_comb begin
        lock_idx = '0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (Harpoon_hit[i]) begin
                lock_idx = ID_W'(i);
            end
        end
    end

    assign lock_now     = (state_q == IDLE) && Harpoon_active && (|Harpoon_hit);
    assign pump_now     = (state_q == LOCKED) && Harpoon_active && Pump_press;
    assign target_level = level[target_q];
    assign pop_done     = (state_q == POPPING) && Frame_tick &&
                          (pop_cnt_q == POP_CNT_W'(POP_FRAMES - 1));

    // Route pump, pop-clear and deflate-hold to the enemy being worked on; a same-cycle lock also holds.
    always_comb begin
        inc  = '0;
        hold = '0;
        clr  = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            inc[i]  = pump_now && (target_q == ID_W'(i));
            clr[i]  = pop_done && (target_q == ID_W'(i));
            hold[i] = ((state_q != IDLE) && (target_q == ID_W'(i))) ||
                      (lock_now && (lock_idx == ID_W'(i)));
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_ENEMIES; g++) begin : g_enemy
            enemy_deflate_timer #(
                .POP_LEVEL      (POP_LEVEL),
                .DEFLATE_FRAMES (DEFLATE_FRAMES)
            ) u_timer (
                .Clk        (Clk),
                .Reset_n    (Reset_n),
                .Frame_tick (Frame_tick),
                .inc        (inc[g]),
                .hold       (hold[g]),
                .clr        (clr[g]),
                .level      (level[g])
            );
            assign Inflate_level[LEVEL_W*g +: LEVEL_W] = level[g];
        end
    endgenerate

    // Lock/pump/pop sequencing with registered target, animation and score pulses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= IDLE;
            target_q       <= '0;
            target_valid_q <= 1'b0;
            pop_anim_q     <= '0;
            popped_q       <= '0;
            score_q        <= 1'b0;
            pop_cnt_q      <= '0;
        end else begin
            popped_q <= '0;
            score_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (lock_now) begin
                        state_q        <= LOCKED;
                        target_q       <= lock_idx;
                        target_valid_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (!Harpoon_active) begin
                        state_q        <= IDLE;
                        target_valid_q <= 1'b0;
                    end else if (Pump_press && (target_level == LEVEL_W'(POP_LEVEL - 1))) begin
                        state_q    <= POPPING;
                        pop_anim_q <= NUM_ENEMIES'(1) << target_q;
                    end
                end
                POPPING: begin
                    if (pop_done) begin
                        state_q        <= IDLE;
                        target_valid_q <= 1'b0;
                        pop_anim_q     <= '0;
                        popped_q       <= NUM_ENEMIES'(1) << target_q;
                        score_q        <= 1'b1;
                        pop_cnt_q      <= '0;
                    end else if (Frame_tick) begin
                        pop_cnt_q <= pop_cnt_q + POP_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // An enemy stays frozen while inflated at all or while the harpoon holds it.
    always_comb begin
        Enemy_frozen = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            Enemy_frozen[i] = (level[i] != '0) || (target_valid_q && (target_q == ID_W'(i)));
        end
    end

    assign Target_valid = target_valid_q;
    assign Target_id    = target_q;
    assign Pop_anim     = pop_anim_q;
    assign Enemy_popped = popped_q;
    assign Score_pulse  = score_q;

endmodule
